ex_mem_reg: RTL and testbench

EX/MEM pipeline register of the 5-stage pipeline. It captures the execute-stage result and control bundle each cycle and presents it to the memory stage. It handles stall (hold) and flush (bubble), refreshes store data that a writeback lands on one cycle late, squashes misaligned memory accesses, and exports an EX/MEM forwarding tap for the hazard unit.

---
 rtl/ex_mem_reg.sv | 145 ++++++++++++++
 tb/tb_ex_mem_reg.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register.
//
// Captures the execute-stage result and control bundle on each rising
// edge and presents it to the memory stage. It also:
//   - holds on stall, loads a bubble on flush (flush wins over stall),
//   - forwards writeback data into the store-data field when the
//     writeback lands on the store's rt register (at capture time and
//     while the entry is held by a stall),
//   - squashes misaligned memory accesses (clears memwe/regwe, flags
//     misalign_o, bumps a saturating error counter),
//   - exports an EX/MEM forwarding tap for the hazard unit.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   valid_i .. aluout_i      EX-stage bundle
//   stall_i, flush_i         hold / bubble controls
//   we_wb, wa_wb, wd_wb      writeback-port snoop
//   valid_o .. aluout_o      registered bundle for the MEM stage
//   misalign_o               held entry was squashed for misalignment
//   err_cnt_o                saturating count of squashed accesses
//   we_em, wa_em, wd_em,     forwarding tap, combinational from the
//   load_em                  registered state only
//
// valid semantics: valid_i/valid_o mark a slot that holds a real
// instruction; there is no backpressure handshake, the stage advances
// every cycle unless stall_i holds it.
module ex_mem_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        cregwa_i,
    input  logic [1:0]  cregwd_i,
    input  logic        regwe_i,
    input  logic [1:0]  memlen_i,
    input  logic        memwe_i,
    input  logic [31:0] rd2_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] aluout_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        we_wb,
    input  logic [4:0]  wa_wb,
    input  logic [31:0] wd_wb,
    output logic        valid_o,
    output logic        cregwa_o,
    output logic [1:0]  cregwd_o,
    output logic        regwe_o,
    output logic [1:0]  memlen_o,
    output logic        memwe_o,
    output logic [31:0] rd2_o,
    output logic [4:0]  rt_o,
    output logic [4:0]  rd_o,
    output logic [31:0] aluout_o,
    output logic        misalign_o,
    output logic [7:0]  err_cnt_o,
    output logic        we_em,
    output logic [4:0]  wa_em,
    output logic [31:0] wd_em,
    output logic        load_em
);

    // Control encodings shared with the decoder.
    localparam logic       CREGWA_RD    = 1'b1;  // write address = rd (else rt)
    localparam logic [1:0] CREGWD_MEMRD = 2'd1;  // write data from memory read

    logic is_mem;
    logic misalign;
    logic fwd_capture;
    logic fwd_hold;

    // Only real memory accesses are checked; byte accesses never fault,
    // memlen 3 behaves as a word access.
    always_comb begin
        is_mem   = valid_i & (memwe_i | (cregwd_i == CREGWD_MEMRD));
        misalign = 1'b0;
        if (is_mem) begin
            if (memlen_i[1]) begin
                misalign = (aluout_i[1:0] != 2'b00);
            end else if (memlen_i == 2'd1) begin
                misalign = aluout_i[0];
            end
        end
    end

    // r0 is hardwired zero and is never forwarded.
    assign fwd_capture = we_wb & (wa_wb != 5'd0) & (wa_wb == rt_i);
    assign fwd_hold    = valid_o & we_wb & (wa_wb != 5'd0) & (wa_wb == rt_o);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o    <= 1'b0;
            cregwa_o   <= 1'b0;
            cregwd_o   <= 2'd0;
            regwe_o    <= 1'b0;
            memlen_o   <= 2'd0;
            memwe_o    <= 1'b0;
            rd2_o      <= 32'd0;
            rt_o       <= 5'd0;
            rd_o       <= 5'd0;
            aluout_o   <= 32'd0;
            misalign_o <= 1'b0;
            err_cnt_o  <= 8'd0;
        end else if (flush_i) begin
            // Bubble: every field cleared, error counter kept.
            valid_o    <= 1'b0;
            cregwa_o   <= 1'b0;
            cregwd_o   <= 2'd0;
            regwe_o    <= 1'b0;
            memlen_o   <= 2'd0;
            memwe_o    <= 1'b0;
            rd2_o      <= 32'd0;
            rt_o       <= 5'd0;
            rd_o       <= 5'd0;
            aluout_o   <= 32'd0;
            misalign_o <= 1'b0;
        end else if (stall_i) begin
            // Held store must still see a writeback that lands while it waits.
            if (fwd_hold) begin
                rd2_o <= wd_wb;
            end
        end else begin
            valid_o    <= valid_i;
            cregwa_o   <= cregwa_i;
            cregwd_o   <= cregwd_i;
            regwe_o    <= regwe_i & ~misalign;
            memlen_o   <= memlen_i;
            memwe_o    <= memwe_i & ~misalign;
            rd2_o      <= fwd_capture ? wd_wb : rd2_i;
            rt_o       <= rt_i;
            rd_o       <= rd_i;
            aluout_o   <= aluout_i;
            misalign_o <= misalign;
            if (misalign && (err_cnt_o != 8'hFF)) begin
                err_cnt_o <= err_cnt_o + 8'd1;
            end
        end
    end

    assign we_em   = regwe_o & valid_o;
    assign wa_em   = (cregwa_o == CREGWA_RD) ? rd_o : rt_o;
    assign wd_em   = aluout_o;
    assign load_em = valid_o & regwe_o & (cregwd_o == CREGWD_MEMRD);

endmodule

// File: tb/tb_ex_mem_reg.sv
// Testbench for ex_mem_reg: directed scenarios plus constrained-random
// cycles, checked against a behavioural model through an expected queue.
module tb_ex_mem_reg;

    localparam int W = 130;
    localparam logic       RD_SEL = 1'b1;
    localparam logic       RT_SEL = 1'b0;
    localparam logic [1:0] ALU    = 2'd0;
    localparam logic [1:0] MEMRD  = 2'd1;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT signals ----------------
    logic        valid_i, cregwa_i, regwe_i, memwe_i, stall_i, flush_i, we_wb;
    logic [1:0]  cregwd_i, memlen_i;
    logic [31:0] rd2_i, aluout_i, wd_wb;
    logic [4:0]  rt_i, rd_i, wa_wb;
    logic        valid_o, cregwa_o, regwe_o, memwe_o, misalign_o, we_em, load_em;
    logic [1:0]  cregwd_o, memlen_o;
    logic [31:0] rd2_o, aluout_o, wd_em;
    logic [4:0]  rt_o, rd_o, wa_em;
    logic [7:0]  err_cnt_o;

    ex_mem_reg dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .cregwa_i(cregwa_i),
        .cregwd_i(cregwd_i), .regwe_i(regwe_i), .memlen_i(memlen_i),
        .memwe_i(memwe_i), .rd2_i(rd2_i), .rt_i(rt_i), .rd_i(rd_i),
        .aluout_i(aluout_i), .stall_i(stall_i), .flush_i(flush_i),
        .we_wb(we_wb), .wa_wb(wa_wb), .wd_wb(wd_wb),
        .valid_o(valid_o), .cregwa_o(cregwa_o), .cregwd_o(cregwd_o),
        .regwe_o(regwe_o), .memlen_o(memlen_o), .memwe_o(memwe_o),
        .rd2_o(rd2_o), .rt_o(rt_o), .rd_o(rd_o), .aluout_o(aluout_o),
        .misalign_o(misalign_o), .err_cnt_o(err_cnt_o), .we_em(we_em),
        .wa_em(wa_em), .wd_em(wd_em), .load_em(load_em)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model state (what the register should hold after each edge).
    logic        m_valid, m_cregwa, m_regwe, m_memwe, m_mis;
    logic [1:0]  m_cregwd, m_memlen;
    logic [31:0] m_rd2, m_alu;
    logic [4:0]  m_rt, m_rd;
    logic [7:0]  m_err;

    function automatic logic [W-1:0] model_vec();
        logic        t_we, t_ld;
        logic [4:0]  t_wa;
        t_we = m_valid & m_regwe;
        t_wa = (m_cregwa == RD_SEL) ? m_rd : m_rt;
        t_ld = m_valid & m_regwe & (m_cregwd == MEMRD);
        return {m_valid, m_cregwa, m_cregwd, m_regwe, m_memlen, m_memwe,
                m_rd2, m_rt, m_rd, m_alu, m_mis, m_err, t_we, t_wa, m_alu, t_ld};
    endfunction

    function automatic logic [W-1:0] dut_vec();
        return {valid_o, cregwa_o, cregwd_o, regwe_o, memlen_o, memwe_o,
                rd2_o, rt_o, rd_o, aluout_o, misalign_o, err_cnt_o,
                we_em, wa_em, wd_em, load_em};
    endfunction

    task automatic model_step();
        logic bad;
        if (rst) begin
            {m_valid, m_cregwa, m_cregwd, m_regwe, m_memlen, m_memwe} = '0;
            {m_rd2, m_rt, m_rd, m_alu, m_mis, m_err} = '0;
        end else if (flush_i) begin
            {m_valid, m_cregwa, m_cregwd, m_regwe, m_memlen, m_memwe} = '0;
            {m_rd2, m_rt, m_rd, m_alu, m_mis} = '0;
        end else if (stall_i) begin
            if (m_valid && we_wb && wa_wb != 0 && wa_wb == m_rt) m_rd2 = wd_wb;
        end else begin
            case (memlen_i)
                2'd0:    bad = 1'b0;
                2'd1:    bad = aluout_i[0];
                default: bad = (aluout_i[1:0] != 0);
            endcase
            if (!(valid_i && (memwe_i || cregwd_i == MEMRD))) bad = 1'b0;
            m_valid  = valid_i;
            m_cregwa = cregwa_i;
            m_cregwd = cregwd_i;
            m_regwe  = bad ? 1'b0 : regwe_i;
            m_memlen = memlen_i;
            m_memwe  = bad ? 1'b0 : memwe_i;
            m_rd2    = (we_wb && wa_wb != 0 && wa_wb == rt_i) ? wd_wb : rd2_i;
            m_rt     = rt_i;
            m_rd     = rd_i;
            m_alu    = aluout_i;
            m_mis    = bad;
            if (bad && m_err < 8'd255) m_err = m_err + 8'd1;
        end
    endtask

    // Compare one edge after each driven cycle.
    always @(posedge clk) begin
        logic [W-1:0] e, g;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = dut_vec();
            check_eq("ctrl",   64'(g[129:122]), 64'(e[129:122]));
            check_eq("rd2",    64'(g[121:90]),  64'(e[121:90]));
            check_eq("rt_rd",  64'(g[89:80]),   64'(e[89:80]));
            check_eq("aluout", 64'(g[79:48]),   64'(e[79:48]));
            check_eq("mis_err",64'(g[47:39]),   64'(e[47:39]));
            check_eq("taps",   64'(g[38:0]),    64'(e[38:0]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        rst = 0; valid_i = 0; cregwa_i = RT_SEL; cregwd_i = ALU; regwe_i = 0;
        memlen_i = 0; memwe_i = 0; rd2_i = 0; rt_i = 0; rd_i = 0; aluout_i = 0;
        stall_i = 0; flush_i = 0; we_wb = 0; wa_wb = 0; wd_wb = 0;
    endtask

    // Inputs are already set (at posedge+2); predict, push, advance one edge.
    task automatic drive_cycle();
        model_step();
        exp_q.push_back(model_vec());
        @(posedge clk);
        #2;
    endtask

    task automatic random_inputs();
        rst      = ($urandom_range(0, 39) == 0);
        valid_i  = ($urandom_range(0, 3) != 0);
        cregwa_i = 1'($urandom_range(0, 1));
        cregwd_i = 2'($urandom_range(0, 1));
        regwe_i  = 1'($urandom_range(0, 1));
        memlen_i = 2'($urandom_range(0, 3));
        memwe_i  = 1'($urandom_range(0, 1));
        rd2_i    = $urandom;
        rt_i     = 5'($urandom_range(0, 7));
        rd_i     = 5'($urandom_range(0, 7));
        aluout_i = $urandom;
        stall_i  = ($urandom_range(0, 3) == 0);
        flush_i  = ($urandom_range(0, 7) == 0);
        we_wb    = 1'($urandom_range(0, 1));
        wa_wb    = 5'($urandom_range(0, 7));
        wd_wb    = $urandom;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        m_valid = 0; m_cregwa = 0; m_cregwd = 0; m_regwe = 0; m_memlen = 0;
        m_memwe = 0; m_rd2 = 0; m_rt = 0; m_rd = 0; m_alu = 0; m_mis = 0; m_err = 0;
        clear_inputs();
        @(posedge clk);
        #2;

        // Reset for two cycles.
        rst = 1;
        drive_cycle();
        drive_cycle();
        check_eq("rst_valid", 64'(valid_o), 64'd0);
        check_eq("rst_err",   64'(err_cnt_o), 64'd0);

        // Plain load.
        clear_inputs();
        valid_i = 1; regwe_i = 1; cregwa_i = RD_SEL; rd_i = 5; aluout_i = 32'h1234;
        drive_cycle();
        check_eq("load_we_em",   64'(we_em), 64'd1);
        check_eq("load_wa_em",   64'(wa_em), 64'd5);
        check_eq("load_wd_em",   64'(wd_em), 64'h1234);
        check_eq("load_load_em", 64'(load_em), 64'd0);
        check_eq("load_mis",     64'(misalign_o), 64'd0);

        // Stall with new inputs: hold.
        rd_i = 11; aluout_i = 32'h9999; stall_i = 1;
        drive_cycle();
        check_eq("stall_wa_em", 64'(wa_em), 64'd5);
        check_eq("stall_wd_em", 64'(wd_em), 64'h1234);

        // Misaligned word store.
        clear_inputs();
        valid_i = 1; memwe_i = 1; memlen_i = 2; aluout_i = 32'h1002;
        drive_cycle();
        check_eq("mis_w_memwe", 64'(memwe_o), 64'd0);
        check_eq("mis_w_flag",  64'(misalign_o), 64'd1);
        check_eq("mis_w_err",   64'(err_cnt_o), 64'd1);

        // Same address as a byte store: fine.
        memlen_i = 0;
        drive_cycle();
        check_eq("byte_memwe", 64'(memwe_o), 64'd1);
        check_eq("byte_flag",  64'(misalign_o), 64'd0);

        // Misaligned half load.
        clear_inputs();
        valid_i = 1; regwe_i = 1; cregwd_i = MEMRD; memlen_i = 1; aluout_i = 32'h1001;
        drive_cycle();
        check_eq("mis_h_regwe", 64'(regwe_o), 64'd0);
        check_eq("mis_h_flag",  64'(misalign_o), 64'd1);
        check_eq("mis_h_err",   64'(err_cnt_o), 64'd2);

        // Stall and flush together: bubble, counter kept.
        stall_i = 1; flush_i = 1;
        drive_cycle();
        check_eq("flush_valid", 64'(valid_o), 64'd0);
        check_eq("flush_alu",   64'(aluout_o), 64'd0);
        check_eq("flush_err",   64'(err_cnt_o), 64'd2);

        // Store-data forward at capture, then r0 not forwarded.
        clear_inputs();
        valid_i = 1; memwe_i = 1; memlen_i = 2; aluout_i = 32'h2000;
        rt_i = 7; rd2_i = 32'hAAAA; we_wb = 1; wa_wb = 7; wd_wb = 32'h5555;
        drive_cycle();
        check_eq("fwd_cap", 64'(rd2_o), 64'h5555);
        wa_wb = 0;
        drive_cycle();
        check_eq("fwd_r0", 64'(rd2_o), 64'hAAAA);

        // Refresh under stall.
        clear_inputs();
        valid_i = 1; memwe_i = 1; memlen_i = 2; aluout_i = 32'h3000; rt_i = 9; rd2_i = 1;
        drive_cycle();
        stall_i = 1; rd2_i = 32'h7777;
        drive_cycle();
        we_wb = 1; wa_wb = 9; wd_wb = 32'hBEEF;
        drive_cycle();
        check_eq("refresh_rd2", 64'(rd2_o), 64'hBEEF);
        check_eq("refresh_alu", 64'(aluout_o), 64'h3000);
        check_eq("refresh_rt",  64'(rt_o), 64'd9);

        // Constrained-random cycles.
        for (int i = 0; i < 300; i++) begin
            random_inputs();
            drive_cycle();
        end

        // Counter saturation.
        clear_inputs();
        valid_i = 1; regwe_i = 1; cregwd_i = MEMRD; memlen_i = 2; aluout_i = 32'h4003;
        for (int i = 0; i < 260; i++) drive_cycle();
        check_eq("sat_err", 64'(err_cnt_o), 64'd255);
        drive_cycle();
        check_eq("sat_hold", 64'(err_cnt_o), 64'd255);

        // Reset mid-stall/flush clears the counter.
        rst = 1; stall_i = 1; flush_i = 1;
        drive_cycle();
        check_eq("rst_clr_err", 64'(err_cnt_o), 64'd0);
        clear_inputs();
        drive_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
